spi_frame_slave: RTL

//  Parametrised SPI slave; successor to the fixed-mode, fixed-length Pico link slave.

---
 rtl/spi_frame_slave.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: SPI slave oversampled on sysClk, one multi-word frame per cs-low window.
// Ports: sysClk/reset; spiClk/mosi/cs in, miso out; tx_data/tx_load/tx_ready shadow load;
//        rx_word/rx_word_valid, rx_data/rx_valid, busy, frame_abort, tx_underrun status.
module spi_frame_slave #(
   parameter int DATA_WIDTH  = 8,
   parameter int TX_WORDS    = 4,
   parameter int RX_WORDS    = 4,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           sysClk,
   input  logic                           reset,
   input  logic                           spiClk,
   input  logic                           mosi,
   input  logic                           cs,
   output logic                           miso,
   input  logic [DATA_WIDTH*TX_WORDS-1:0] tx_data,
   input  logic                           tx_load,
   output logic                           tx_ready,
   output logic [DATA_WIDTH-1:0]          rx_word,
   output logic                           rx_word_valid,
   output logic [DATA_WIDTH*RX_WORDS-1:0] rx_data,
   output logic                           rx_valid,
   output logic                           busy,
   output logic                           frame_abort,
   output logic                           tx_underrun
);

   localparam int MAXW = (TX_WORDS > RX_WORDS) ? TX_WORDS : RX_WORDS;
   localparam int FB   = DATA_WIDTH * MAXW;
   localparam int TXB  = DATA_WIDTH * TX_WORDS;
   localparam int RXB  = DATA_WIDTH * RX_WORDS;
   localparam int BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int WW   = $clog2(MAXW + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(MAXW - 1);
   localparam bit SAMPLE_RISE = (CPOL == CPHA);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sck_q, mosi_q, cs_q;
   logic sck_rise, sck_fall, sample_edge, shift_edge;
   logic mosi_s, cs_low, cs_fall, word_end, last_bit;

   logic [FB-1:0]  tx_sr;
   logic [FB-2:0]  rx_sr;
   logic [FB-1:0]  rx_next;
   logic [TXB-1:0] shadow;
   logic           shadow_full;
   logic           tx_en;
   logic [BW-1:0]  bit_cnt;
   logic [WW-1:0]  word_cnt;

   // Reset preloads the chains with the live pin levels so no false
   // edge (in particular no cs fall) appears right after reset.
   always_ff @(posedge sysClk) begin
      if (reset) begin
         sck_q  <= {SYNC_STAGES{spiClk}};
         mosi_q <= {SYNC_STAGES{mosi}};
         cs_q   <= {SYNC_STAGES{cs}};
      end else begin
         sck_q  <= {sck_q[SYNC_STAGES-2:0], spiClk};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
         cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
      end
   end

   assign sck_rise    = sck_q[SYNC_STAGES-2] & ~sck_q[SYNC_STAGES-1];
   assign sck_fall    = ~sck_q[SYNC_STAGES-2] & sck_q[SYNC_STAGES-1];
   assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
   assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
   // mosi settled half an spiClk period before the sample edge
   assign mosi_s      = mosi_q[SYNC_STAGES-1];
   assign cs_low      = ~cs_q[SYNC_STAGES-2];
   assign cs_fall     = ~cs_q[SYNC_STAGES-2] & cs_q[SYNC_STAGES-1];
   assign word_end    = sample_edge & (bit_cnt == BIT_LAST);
   assign last_bit    = word_end & (word_cnt == WORD_LAST);
   assign rx_next     = {rx_sr, mosi_s};
   assign tx_ready    = ~shadow_full;

   always_ff @(posedge sysClk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall) state_d = ACTIVE;
         ACTIVE:  if (!cs_low) state_d = IDLE;
                  else if (last_bit) state_d = DONE;
         DONE:    if (!cs_low) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ACTIVE);
      miso = (state_q == ACTIVE) & tx_en & tx_sr[FB-1];
   end

   always_ff @(posedge sysClk) begin
      if (reset) begin
         tx_sr         <= '0;
         rx_sr         <= '0;
         shadow        <= '0;
         shadow_full   <= 1'b0;
         tx_en         <= 1'b0;
         bit_cnt       <= '0;
         word_cnt      <= '0;
         rx_word       <= '0;
         rx_word_valid <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         frame_abort   <= 1'b0;
         tx_underrun   <= 1'b0;
      end else begin
         rx_word_valid <= 1'b0;
         rx_valid      <= 1'b0;
         frame_abort   <= 1'b0;
         tx_underrun   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  bit_cnt  <= '0;
                  word_cnt <= '0;
                  // CPHA=1 holds off the first bit until the leading edge
                  tx_en    <= (CPHA == 0);
                  if (shadow_full) begin
                     tx_sr       <= FB'(shadow) << (FB - TXB);
                     shadow_full <= 1'b0;
                  end else begin
                     tx_sr       <= '0;
                     tx_underrun <= 1'b1;
                  end
               end
            end
            ACTIVE: begin
               if (!cs_low) begin
                  frame_abort <= 1'b1;
                  bit_cnt     <= '0;
                  word_cnt    <= '0;
                  tx_en       <= 1'b0;
               end else begin
                  if (sample_edge) begin
                     rx_sr   <= rx_next[FB-2:0];
                     bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
                  end
                  if (word_end) begin
                     rx_word       <= rx_next[DATA_WIDTH-1:0];
                     rx_word_valid <= 1'b1;
                     word_cnt      <= word_cnt + 1'b1;
                  end
                  if (last_bit) begin
                     rx_data  <= rx_next[FB-1 -: RXB];
                     rx_valid <= 1'b1;
                     word_cnt <= '0;
                  end
                  if (shift_edge) begin
                     if (tx_en) tx_sr <= {tx_sr[FB-2:0], 1'b0};
                     else       tx_en <= 1'b1;
                  end
               end
            end
            default: tx_en <= 1'b0;
         endcase
         // after the frame-start copy so a coincident load stays queued
         if (tx_load) begin
            shadow      <= tx_data;
            shadow_full <= 1'b1;
         end
      end
   end

endmodule
